// File: rtl/ffd_shift_ctrl_if.sv
// ffd_shift_ctrl_if: word handshake, shift controls and serial outputs of ffd_shift_ctrl
interface ffd_shift_ctrl_if #(parameter int WIDTH = 8);
    localparam int CNT_W = $clog2(WIDTH + 1);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_in;
    logic             pause;
    logic             abort;
    logic             sout;
    logic             sout_valid;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] bit_cnt;
    modport master (output in_valid, data_in, pause, abort,
                    input in_ready, sout, sout_valid, busy, done, bit_cnt);
    modport slave  (input in_valid, data_in, pause, abort,
                    output in_ready, sout, sout_valid, busy, done, bit_cnt);
endinterface

// File: rtl/ffd_shift_ctrl.sv
// ffd_shift_ctrl: parallel-in, serial-out (LSB first) shifter controller with pause and abort
module ffd_shift_ctrl #(parameter int WIDTH = 8) (
    input logic clock,
    input logic reset,
    ffd_shift_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [CNT_W-1:0] bit_cnt, cnt_n;
    logic             vld, vld_n;
    logic             last;
    assign last = bit_cnt == CNT_W'(WIDTH - 1);
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            vld     <= 1'b0;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            bit_cnt <= cnt_n;
            vld     <= vld_n;
        end
    end
    // A bit is consumed at the edge closing its valid cycle; a paused edge holds the bit with valid low
    always_comb begin
        state_n = state;
        shreg_n = shreg;
        cnt_n   = bit_cnt;
        vld_n   = 1'b0;
        if (bus.abort && state != IDLE) begin
            state_n = IDLE;
            shreg_n = '0;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    state_n = SHIFT;
                    shreg_n = bus.data_in;
                    cnt_n   = '0;
                    vld_n   = 1'b1;
                end
                SHIFT: if (!bus.pause) begin
                    shreg_n = shreg >> 1;
                    cnt_n   = bit_cnt + CNT_W'(1);
                    state_n = last ? DONE : SHIFT;
                    vld_n   = !last;
                end
                default: begin
                    state_n = IDLE;
                    shreg_n = '0;
                    cnt_n   = '0;
                end
            endcase
        end
    end
    assign bus.in_ready   = state == IDLE;
    assign bus.busy       = state != IDLE;
    assign bus.done       = state == DONE;
    assign bus.sout       = state == SHIFT && shreg[0];
    assign bus.sout_valid = vld;
    assign bus.bit_cnt    = bit_cnt;
endmodule

// File: tb/tb_ffd_shift_ctrl.sv
// tb_ffd_shift_ctrl: directed and random stimulus against a word-level model with a bit/done scoreboard
module tb_ffd_shift_ctrl;
    localparam int W = 8;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   left = -1;
    logic held = 1'b0;
    int   exp_q[$];
    ffd_shift_ctrl_if #(.WIDTH(W)) bus ();
    ffd_shift_ctrl #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus));
    always #5 clock = ~clock;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endfunction

    // Word-level model: left = bits still to emit (-1 idle, 0 the done cycle)
    task automatic model_edge();
        if (left >= 0 && bus.abort) begin
            left = -1;
            exp_q.delete();
        end else if (left < 0) begin
            if (bus.in_valid) begin
                for (int i = 0; i < W; i++) exp_q.push_back(int'(bus.data_in[i]));
                exp_q.push_back(2);
                left = W;
                held = 1'b0;
            end
        end else if (left == 0) begin
            left = -1;
        end else if (bus.pause) begin
            held = 1'b1;
        end else begin
            left--;
            held = 1'b0;
        end
    endtask

    task automatic cyc(input logic v, input logic [W-1:0] d, input logic p, input logic a);
        bus.in_valid = v;
        bus.data_in  = d;
        bus.pause    = p;
        bus.abort    = a;
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0);
    endtask

    always @(negedge clock) begin
        chk("in_ready", int'(bus.in_ready), int'(left < 0));
        chk("busy", int'(bus.busy), int'(left >= 0));
        chk("done", int'(bus.done), int'(left == 0));
        chk("bit_cnt", int'(bus.bit_cnt), left < 0 ? 0 : W - left);
        chk("sout_valid", int'(bus.sout_valid), int'(left > 0 && !held));
        if (left <= 0) chk("sout_quiet", int'(bus.sout), 0);
        if (bus.sout_valid || bus.done) begin
            if (exp_q.size() == 0) chk("scoreboard_empty", 1, 0);
            else chk(bus.done ? "done_order" : "sout_bit", bus.done ? 2 : int'(bus.sout), exp_q.pop_front());
        end
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.data_in  = '0;
        bus.pause    = 1'b0;
        bus.abort    = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        // A5 plain serialisation
        cyc(1'b1, 8'hA5, 1'b0, 1'b0);
        idle(11);
        // FF with a three-cycle pause once two bits are out
        cyc(1'b1, 8'hFF, 1'b0, 1'b0);
        idle(2);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        idle(10);
        // 3C aborted at bit_cnt 4, then 01
        cyc(1'b1, 8'h3C, 1'b0, 1'b0);
        idle(4);
        chk("cnt_before_abort", int'(bus.bit_cnt), 4);
        cyc(1'b0, '0, 1'b0, 1'b1);
        idle(3);
        cyc(1'b1, 8'h01, 1'b0, 1'b0);
        idle(11);
        // asynchronous reset mid-word
        cyc(1'b1, 8'hC3, 1'b0, 1'b0);
        idle(5);
        chk("cnt_before_reset", int'(bus.bit_cnt), 5);
        #2 reset = 1'b1;
        left = -1;
        held = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_sout", int'(bus.sout), 0);
        chk("rst_sout_valid", int'(bus.sout_valid), 0);
        chk("rst_bit_cnt", int'(bus.bit_cnt), 0);
        @(posedge clock);
        #1 reset = 1'b0;
        chk("post_rst_ready", int'(bus.in_ready), 1);
        idle(2);
        // in_valid held high across two words
        cyc(1'b1, 8'h12, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 8'h34, 1'b0, 1'b0);
        idle(12);
        // abort with in_valid in IDLE still accepts
        cyc(1'b1, 8'h80, 1'b0, 1'b1);
        idle(8);
        chk("msb_done_cnt", int'(bus.bit_cnt), W);
        idle(3);
        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0, 2) == 0, W'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
        idle(30);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
